// File: rtl/regfile_scan_reader_pkg.sv
// Shared types and constants for the register-file scan reader.
package regfile_scan_reader_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_ADDRW = 4;
  localparam int REG_DATAW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    SEND,
    DONE
  } scan_state_t;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Output word stream: valid/ready handshake carrying data, register index and last flag.
interface regfile_scan_reader_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRW     = 4
);

  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_data;
  logic [ADDRW-1:0]     out_index;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_scan_reader_scan_addr_counter.sv
// Loadable modulo-2^ADDRW scan address counter; also holds the end address and flags cur==end.
module scan_addr_counter #(
  parameter int ADDRW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [ADDRW-1:0] load_first,
  input  logic [ADDRW-1:0] load_last,
  input  logic             inc,
  output logic [ADDRW-1:0] cur,
  output logic             at_end
);

  logic [ADDRW-1:0] end_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= '0;
      end_addr <= '0;
    end else if (load) begin
      cur      <= load_first;
      end_addr <= load_last;
    end else if (inc) begin
      cur      <= cur + 1'b1;
    end
  end

  assign at_end = (cur == end_addr);

endmodule

// File: rtl/regfile_scan_reader.sv
// Debug read-out engine: walks a (wrapping) register range through one read port and streams each word out.
module regfile_scan_reader
  import regfile_scan_reader_pkg::*;
#(
  parameter int DATAWIDTH = REG_DATAW,
  parameter int ADDRW     = REG_ADDRW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDRW-1:0]      first_addr,
  input  logic [ADDRW-1:0]      last_addr,
  output logic [ADDRW-1:0]      rf_addr,
  input  logic [DATAWIDTH-1:0]  rf_data,
  output logic                  busy,
  output logic                  done,
  regfile_scan_reader_if.master stream
);

  scan_state_t state, state_next;

  logic                 load;
  logic                 inc;
  logic                 at_end;
  logic                 handshake;
  logic [ADDRW-1:0]     cur;

  logic                 valid_q;
  logic [DATAWIDTH-1:0] data_q;
  logic [ADDRW-1:0]     index_q;
  logic                 last_q;

  scan_addr_counter #(
    .ADDRW (ADDRW)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_first (first_addr),
    .load_last  (last_addr),
    .inc        (inc),
    .cur        (cur),
    .at_end     (at_end)
  );

  assign handshake = valid_q && stream.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    inc        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ADDR;
        end
      end
      ADDR: state_next = SEND;
      SEND: begin
        if (handshake) begin
          if (last_q) begin
            state_next = DONE;
          end else begin
            inc        = 1'b1;
            state_next = ADDR;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture happens on the ADDR edge; the word then holds until it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else if (state == ADDR) begin
      valid_q <= 1'b1;
      data_q  <= rf_data;
      index_q <= cur;
      last_q  <= at_end;
    end else if (state == SEND && handshake) begin
      valid_q <= 1'b0;
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_index = index_q;
  assign stream.out_last  = last_q;

  assign rf_addr = cur;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule
